square_reconstruct: RTL and testbench

//  Iterative squarer: the inverse of the square-root unit. Takes a root and a

---
 rtl/square_reconstruct.sv | 118 +++++++++++
 tb/tb_square_reconstruct.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/square_reconstruct.sv
// Iterative squarer: rebuilds radicand O = Root*Root + Rem, one shift-add per clock.
// Flags remainders larger than 2*Root, which no square-root result can produce.
module square_reconstruct #(
  parameter int W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [W-1:0]     Root,
  input  logic [W:0]       Rem,
  output logic [2*W-1:0]   O,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mult_q, mult_d;
  logic [CW-1:0]   count_q, count_d;
  logic            errl_q, errl_d;
  logic [2*W-1:0]  o_q, o_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*W-1:0]  acc_add;

  assign O    = o_q;
  assign Err  = err_q;
  assign Busy = busy_q;
  assign Done = done_q;

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      count_q <= '0;
      errl_q  <= 1'b0;
      o_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      count_q <= count_d;
      errl_q  <= errl_d;
      o_q     <= o_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and shift-add step; O/Err only change on the final step.
  always_comb begin
    acc_add = mult_q[0] ? acc_q + mcand_q : acc_q;
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    count_d = count_q;
    errl_d  = errl_q;
    o_d     = o_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = MUL;
          mcand_d = {{W{1'b0}}, Root};
          mult_d  = Root;
          acc_d   = {{(W-1){1'b0}}, Rem};
          count_d = '0;
          errl_d  = Rem > {Root, 1'b0};
          busy_d  = 1'b1;
        end
      end
      MUL: begin
        acc_d   = acc_add;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
          count_d = '0;
          o_d     = acc_add;
          err_d   = errl_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_square_reconstruct.sv
// Scoreboard bench for square_reconstruct: driver queues expected results,
// a negedge monitor pops and compares on every Done.
module tb_square_reconstruct;

  localparam int W = 16;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic [W-1:0]    Root;
  logic [W:0]      Rem;
  logic [2*W-1:0]  O;
  logic            Busy;
  logic            Done;
  logic            Err;

  typedef struct {
    logic [2*W-1:0] o;
    logic           err;
    int             acc;
  } exp_t;

  exp_t           sb[$];
  int             checks;
  int             failures;
  int             cyc;
  int             bcnt;
  logic [2*W-1:0] last_o;
  logic           last_err;

  square_reconstruct #(.W(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Root  (Root),
    .Rem   (Rem),
    .O     (O),
    .Busy  (Busy),
    .Done  (Done),
    .Err   (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic from the definition.
  function automatic exp_t model(input logic [W-1:0] r,
                                 input logic [W:0] m, input int acc);
    exp_t e;
    longint unsigned full;
    full  = longint'(r) * longint'(r) + longint'(m);
    e.o   = full[2*W-1:0];
    e.err = longint'(m) > 2 * longint'(r);
    e.acc = acc;
    return e;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy !== 1'b0 || Done !== 1'b0) begin
      step();
      n++;
      if (n > 100) begin
        chk("idle_timeout", 64'(n), 64'(0));
        break;
      end
    end
  endtask

  task automatic issue(input logic [W-1:0] r, input logic [W:0] m);
    wait_idle();
    Root  = r;
    Rem   = m;
    Start = 1'b1;
    sb.push_back(model(r, m, cyc + 1));
    step();
    Start = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  // Monitor: result/latency/busy checks at Done, hold checks otherwise.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      sb.delete();
      last_o   = '0;
      last_err = 1'b0;
      bcnt     = 0;
      chk("reset_outs", {30'd0, O, Busy, Done, Err}, 64'd0);
    end else begin
      if (Busy) bcnt++;
      if (Done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result_O", 64'(O), 64'(e.o));
          chk("result_Err", 64'(Err), 64'(e.err));
          chk("latency", 64'(cyc), 64'(e.acc + W));
          chk("busy_cycles", 64'(bcnt), 64'(W));
          last_o   = e.o;
          last_err = e.err;
        end
        bcnt = 0;
      end else begin
        chk("hold_O", 64'(O), 64'(last_o));
        chk("hold_Err", 64'(Err), 64'(last_err));
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    logic [W:0]   m;
    int           n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    bcnt     = 0;
    last_o   = '0;
    last_err = 1'b0;
    Reset    = 1'b1;
    Start    = 1'b0;
    Root     = '0;
    Rem      = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    issue(16'd0, 17'd0);
    issue(16'd255, 17'd0);
    issue(16'hFFFF, 17'd131070);
    issue(16'd3, 17'd7);
    issue(16'd3, 17'd6);

    // Start held high: one job per W+2 cycles, Root changed mid-run.
    wait_idle();
    Root  = 16'd10;
    Rem   = 17'd1;
    Start = 1'b1;
    sb.push_back(model(Root, Rem, cyc + 1));
    repeat (W + 2) step();
    sb.push_back(model(Root, Rem, cyc + 1));
    repeat (5) step();
    Root = 16'd20;
    repeat (W + 2 - 5) step();
    sb.push_back(model(Root, Rem, cyc + 1));
    step();
    Start = 1'b0;

    // Reset mid-operation: job abandoned, no Done.
    issue(16'd1000, 17'd5);
    repeat (7) step();
    pulse_reset();
    chk("post_reset_busy", 64'(Busy), 64'd0);
    chk("post_reset_done", 64'(Done), 64'd0);
    repeat (W + 4) step();
    issue(16'd1000, 17'd5);

    for (int i = 0; i < 20; i++) begin
      r = W'($urandom);
      if (i % 2 == 0) m = (W+1)'($urandom_range(0, 2 * int'(r)));
      else m = (W+1)'($urandom_range(0, 131071));
      issue(r, m);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
